// File: rtl/jesd204_fec_pkg.sv
// rtl/jesd204_fec_pkg.sv - shared constants, state type and sync-header encoder for the TX FEC header inserter
package jesd204_fec_pkg;

    localparam int FEC_WIDTH = 26;
    localparam int MB_BLOCKS = 32;
    localparam logic [5:0] PILOT = 6'b000001;

    localparam logic [1:0] HDR_ONE  = 2'b10;
    localparam logic [1:0] HDR_ZERO = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN
    } fec_state_e;

    // Multiblock header word is {parity, pilot}, sent MSb first, one bit per block.
    function automatic logic [1:0] fec_header_encode(
        input logic [FEC_WIDTH-1:0] fec,
        input logic [4:0]           blk
    );
        logic [MB_BLOCKS-1:0] hdr_word;
        logic [4:0]           idx;
        hdr_word = {fec, PILOT};
        idx      = 5'd31 - blk;
        return hdr_word[idx] ? HDR_ONE : HDR_ZERO;
    endfunction

endpackage

// File: rtl/jesd204_fec_delay_ram.sv
// rtl/jesd204_fec_delay_ram.sv - 1R1W ring-buffer storage with registered read for the block delay line
module jesd204_fec_delay_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 64,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage is never cleared; only the read register is reset so the output is quiet.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Same-address read and write return the old word: that is the delay tap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/jesd204_tx_fec_header_insert.sv
// rtl/jesd204_tx_fec_header_insert.sv - delays the 64b block stream by whole multiblocks and inserts FEC parity into the sync headers
module jesd204_tx_fec_header_insert #(
    parameter int DATA_WIDTH = 64,
    parameter int FEC_WIDTH  = 26,
    parameter int DELAY_MB   = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_eomb,
    input  logic [FEC_WIDTH-1:0]  fec_in,
    input  logic                  fec_in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_header,
    output logic                  out_valid,
    output logic                  out_eomb,
    output logic                  status_fec_missing,
    output logic                  status_fec_overrun
);

    import jesd204_fec_pkg::*;

    localparam int            DEPTH    = MB_BLOCKS * DELAY_MB;
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    fec_state_e           r_state;
    logic [AW-1:0]        r_wr_idx;
    logic [4:0]           r_blk_idx;
    logic [FEC_WIDTH-1:0] r_pending;
    logic                 r_pending_full;
    logic [FEC_WIDTH-1:0] r_active;
    logic                 r_out_valid;
    logic                 r_out_eomb;
    logic [1:0]           r_out_header;
    logic                 r_fec_missing;
    logic                 r_fec_overrun;

    logic                 w_beat;
    logic                 w_misalign;
    logic                 w_emit;
    logic                 w_wr_en;
    logic                 w_consume;
    logic [FEC_WIDTH-1:0] w_fec_sel;

    // Depth is a whole number of multiblocks, so the low write-index bits are the input block index.
    assign w_beat     = in_valid && (r_state != ST_IDLE);
    assign w_misalign = w_beat && in_eomb && (r_wr_idx[4:0] != 5'd31);
    assign w_emit     = in_valid && (r_state == ST_RUN) && !w_misalign;
    assign w_wr_en    = w_beat && !w_misalign;
    assign w_consume  = w_emit && (r_blk_idx == 5'd0);
    assign w_fec_sel  = w_consume ? (r_pending_full ? r_pending : '0) : r_active;

    jesd204_fec_delay_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_delay_ram (
        .clk       (clk),
        .resetn    (resetn),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_idx),
        .i_wr_data (in_data),
        .i_rd_en   (w_emit),
        .i_rd_addr (r_wr_idx),
        .o_rd_data (out_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_wr_idx       <= '0;
            r_blk_idx      <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_active       <= '0;
            r_out_valid    <= 1'b0;
            r_out_eomb     <= 1'b0;
            r_out_header   <= 2'b00;
            r_fec_missing  <= 1'b0;
            r_fec_overrun  <= 1'b0;
        end else begin
            r_out_valid   <= 1'b0;
            r_out_eomb    <= 1'b0;
            r_fec_missing <= 1'b0;
            r_fec_overrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_eomb) begin
                        r_state   <= ST_PRIME;
                        r_wr_idx  <= '0;
                        r_blk_idx <= '0;
                    end
                end
                default: begin
                    if (w_misalign) begin
                        r_state        <= ST_IDLE;
                        r_pending_full <= 1'b0;
                        r_active       <= '0;
                    end else begin
                        if (in_valid) begin
                            r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + 1'b1;
                            if ((r_state == ST_PRIME) && (r_wr_idx == LAST_IDX)) begin
                                r_state <= ST_RUN;
                            end
                        end
                        if (w_emit) begin
                            r_out_valid  <= 1'b1;
                            r_out_eomb   <= (r_blk_idx == 5'd31);
                            r_out_header <= fec_header_encode(w_fec_sel, r_blk_idx);
                            r_active     <= w_fec_sel;
                            r_blk_idx    <= r_blk_idx + 5'd1;
                            if (w_consume && !r_pending_full) begin
                                r_fec_missing <= 1'b1;
                            end
                        end
                        // A same-cycle consume frees the slot, so a simultaneous load is not an overrun.
                        if (fec_in_valid) begin
                            r_pending      <= fec_in;
                            r_pending_full <= 1'b1;
                            if (r_pending_full && !w_consume) begin
                                r_fec_overrun <= 1'b1;
                            end
                        end else if (w_consume) begin
                            r_pending_full <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign out_header         = r_out_header;
    assign out_valid          = r_out_valid;
    assign out_eomb           = r_out_eomb;
    assign status_fec_missing = r_fec_missing;
    assign status_fec_overrun = r_fec_overrun;

endmodule

// File: tb/tb_jesd204_tx_fec_header_insert.sv
// tb/tb_jesd204_tx_fec_header_insert.sv - directed self-checking bench for jesd204_tx_fec_header_insert
module tb_jesd204_tx_fec_header_insert;

    localparam logic [63:0] DBASE = 64'hC0DE_0000_0000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_eomb;
    logic [25:0] fec_in;
    logic        fec_in_valid;
    logic [63:0] out_data;
    logic [1:0]  out_header;
    logic        out_valid;
    logic        out_eomb;
    logic        status_fec_missing;
    logic        status_fec_overrun;

    int errors = 0;
    int checks = 0;

    logic [63:0] cap_data [$];
    logic [1:0]  cap_hdr  [$];
    logic        cap_eomb [$];
    logic        cap_miss [$];
    int          cur_beat;
    int          first_valid;
    int          ovr_count;
    int          ovr_beat;

    always #5 clk = ~clk;

    jesd204_tx_fec_header_insert #(
        .DATA_WIDTH (64),
        .FEC_WIDTH  (26),
        .DELAY_MB   (2)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_eomb            (in_eomb),
        .fec_in             (fec_in),
        .fec_in_valid       (fec_in_valid),
        .out_data           (out_data),
        .out_header         (out_header),
        .out_valid          (out_valid),
        .out_eomb           (out_eomb),
        .status_fec_missing (status_fec_missing),
        .status_fec_overrun (status_fec_overrun)
    );

    function automatic logic [1:0] exp_hdr(input logic [25:0] f, input int b);
        logic [25:0] t;
        logic        bitv;
        if (b < 26) begin
            t    = f >> (25 - b);
            bitv = t[0];
        end else begin
            bitv = (b == 31);
        end
        return bitv ? 2'b10 : 2'b01;
    endfunction

    task automatic drive(input logic v, input logic [63:0] d, input logic e,
                         input logic fv, input logic [25:0] f);
        in_valid     = v;
        in_data      = d;
        in_eomb      = e;
        fec_in_valid = fv;
        fec_in       = f;
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            cap_data.push_back(out_data);
            cap_hdr.push_back(out_header);
            cap_eomb.push_back(out_eomb);
            cap_miss.push_back(status_fec_missing);
            if (first_valid < 0) first_valid = cur_beat;
        end
        if (status_fec_overrun === 1'b1) begin
            ovr_count++;
            ovr_beat = cur_beat;
        end
        in_valid     = 1'b0;
        in_eomb      = 1'b0;
        fec_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        in_valid     = 1'b0;
        in_eomb      = 1'b0;
        in_data      = '0;
        fec_in       = '0;
        fec_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        cap_data.delete();
        cap_hdr.delete();
        cap_eomb.delete();
        cap_miss.delete();
        cur_beat    = -1;
        first_valid = -1;
        ovr_count   = 0;
        ovr_beat    = -1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        checks++;
        if ({out_data, out_header, out_valid, out_eomb, status_fec_missing, status_fec_overrun} !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h hdr=%b v=%b e=%b m=%b o=%b, expected all 0",
                     out_data, out_header, out_valid, out_eomb, status_fec_missing, status_fec_overrun);
        end
        do_reset();
        drive(1'b1, 64'h1, 1'b0, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_output: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_fec_insert();
        logic [25:0] mb_fec [3];
        logic        fv;
        logic [25:0] f;
        mb_fec[0] = 26'h2AAAAAA;
        mb_fec[1] = 26'h0000000;
        mb_fec[2] = 26'h1C3A5F0;
        do_reset();
        drive(1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0, '0);
        for (int i = 0; i < 160; i++) begin
            cur_beat = i;
            fv = 1'b0;
            f  = '0;
            if (i == 58)  begin fv = 1'b1; f = 26'h2AAAAAA; end
            if (i == 122) begin fv = 1'b1; f = 26'h0F0F0F0; end
            if (i == 125) begin fv = 1'b1; f = 26'h1C3A5F0; end
            drive(1'b1, DBASE | 64'(i), (i % 32) == 31, fv, f);
        end
        checks++;
        if (first_valid != 64) begin
            errors++;
            $display("FAIL first_valid_beat: got %0d, expected 64", first_valid);
        end
        checks++;
        if (cap_data.size() != 96) begin
            errors++;
            $display("FAIL output_count: got %0d, expected 96", cap_data.size());
        end
        for (int k = 0; k < 96 && k < cap_data.size(); k++) begin
            checks++;
            if (cap_data[k] !== (DBASE | 64'(k))) begin
                errors++;
                $display("FAIL out_data[%0d]: got %h, expected %h", k, cap_data[k], DBASE | 64'(k));
            end
            checks++;
            if (cap_eomb[k] !== ((k % 32) == 31)) begin
                errors++;
                $display("FAIL out_eomb[%0d]: got %b, expected %b", k, cap_eomb[k], (k % 32) == 31);
            end
            checks++;
            if (cap_hdr[k] !== exp_hdr(mb_fec[k / 32], k % 32)) begin
                errors++;
                $display("FAIL out_header[%0d]: got %b, expected %b", k, cap_hdr[k], exp_hdr(mb_fec[k / 32], k % 32));
            end
            checks++;
            if (cap_miss[k] !== (k == 32)) begin
                errors++;
                $display("FAIL fec_missing[%0d]: got %b, expected %b", k, cap_miss[k], k == 32);
            end
        end
        checks++;
        if (ovr_count != 1 || ovr_beat != 125) begin
            errors++;
            $display("FAIL fec_overrun: got count=%0d beat=%0d, expected count=1 beat=125", ovr_count, ovr_beat);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        drive(1'b1, 64'h0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 96; i++) begin
            cur_beat = i;
            drive(1'b1, DBASE | 64'(i), (i % 32) == 31, i == 58, (i == 58) ? 26'h2AAAAAA : 26'h0);
            if (i >= 64) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_valid_beat%0d: got out_valid=%b, expected 1", i, out_valid);
                end
            end
            drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, '0);
            if (i >= 64) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_idle_after%0d: got out_valid=%b, expected 0", i, out_valid);
                end
            end
        end
        checks++;
        if (first_valid != 64 || cap_data.size() != 32) begin
            errors++;
            $display("FAIL gap_output_count: got first=%0d count=%0d, expected first=64 count=32",
                     first_valid, cap_data.size());
        end
        for (int k = 0; k < 32 && k < cap_data.size(); k++) begin
            checks++;
            if (cap_data[k] !== (DBASE | 64'(k)) || cap_hdr[k] !== exp_hdr(26'h2AAAAAA, k)
                || cap_eomb[k] !== (k == 31)) begin
                errors++;
                $display("FAIL gap_out[%0d]: got data=%h hdr=%b eomb=%b, expected data=%h hdr=%b eomb=%b",
                         k, cap_data[k], cap_hdr[k], cap_eomb[k], DBASE | 64'(k), exp_hdr(26'h2AAAAAA, k), k == 31);
            end
        end
    endtask

    task automatic test_misalign();
        do_reset();
        drive(1'b1, 64'h0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 82; i++) begin
            cur_beat = i;
            drive(1'b1, DBASE | 64'(i), ((i % 32) == 31) || (i == 81), 1'b0, '0);
            if (i == 80) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL misalign_pre_run: got out_valid=%b, expected 1", out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_drop: got out_valid=%b, expected 0", out_valid);
        end
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, DBASE, 1'b0, 1'b0, '0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_idle%0d: got out_valid=%b, expected 0", j, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 64'h0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 70; i++) begin
            cur_beat = i;
            drive(1'b1, DBASE | 64'(i), (i % 32) == 31, 1'b0, '0);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== (DBASE | 64'd5)) begin
            errors++;
            $display("FAIL mid_run_state: got v=%b data=%h, expected v=1 data=%h", out_valid, out_data, DBASE | 64'd5);
        end
        in_valid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({out_data, out_header, out_valid, out_eomb, status_fec_missing, status_fec_overrun} !== 70'd0) begin
            errors++;
            $display("FAIL async_reset_clear: got data=%h hdr=%b v=%b, expected all 0", out_data, out_header, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_data, out_header, out_valid, out_eomb, status_fec_missing, status_fec_overrun} !== 70'd0) begin
            errors++;
            $display("FAIL reset_hold_clear: got data=%h hdr=%b v=%b, expected all 0", out_data, out_header, out_valid);
        end
        in_valid = 1'b0;
        resetn   = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fec_insert();
        test_gaps();
        test_misalign();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
